// File: rtl/spi_defines.sv
// Shared SPI constants and the transfer-controller state encoding.
// Imported by the SPI blocks that share character length and select width.
package spi_defines;

    localparam int SPI_CHAR_LEN_BITS = 7;
    localparam int SPI_SS_NB         = 8;
    localparam int SPI_DIVIDER_LEN   = 16;

    // One-hot state encoding; the bit indices are used for decoding.
    localparam int IDLE_B = 0;
    localparam int RUN_B  = 1;
    localparam int FIN_B  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_RUN    = 3'b010,
        ST_FINISH = 3'b100
    } xfer_state_t;

endpackage

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: sequences one character through the clock
// generator, counts falling edges, and raises done/irq on completion.
//
// Ports:
//   clk_in, rst          system clock, async active-high reset
//   start, abort         request / terminate a transfer
//   char_len             bits per transfer (0 means 2^SPI_CHAR_LEN_BITS)
//   ss_sel, ass          slave mask, automatic(1)/manual(0) select
//   ie, irq_clr          interrupt enable / clear
//   cg_pos_edge/neg_edge edge pulses from the clock generator
//   cg_enable/go/last_clk controls to the clock generator
//   busy, done, irq      status
//   bit_cnt              bits remaining
//   ss_pad_o             active-low slave selects
module spi_xfer_ctrl
    import spi_defines::xfer_state_t,
           spi_defines::ST_IDLE,
           spi_defines::ST_RUN,
           spi_defines::ST_FINISH,
           spi_defines::IDLE_B,
           spi_defines::RUN_B,
           spi_defines::FIN_B;
#(
    parameter int SPI_CHAR_LEN_BITS = spi_defines::SPI_CHAR_LEN_BITS,
    parameter int SPI_SS_NB         = spi_defines::SPI_SS_NB
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [SPI_CHAR_LEN_BITS-1:0] char_len,
    input  logic [SPI_SS_NB-1:0]       ss_sel,
    input  logic                       ass,
    input  logic                       ie,
    input  logic                       irq_clr,
    input  logic                       cg_pos_edge,
    input  logic                       cg_neg_edge,
    output logic                       cg_enable,
    output logic                       cg_go,
    output logic                       cg_last_clk,
    output logic                       busy,
    output logic                       done,
    output logic                       irq,
    output logic [SPI_CHAR_LEN_BITS:0] bit_cnt,
    output logic [SPI_SS_NB-1:0]       ss_pad_o
);

    localparam int CW = SPI_CHAR_LEN_BITS;
    localparam logic [CW:0] FULL_CNT = {1'b1, {CW{1'b0}}};
    localparam logic [CW:0] ONE_CNT  = {{CW{1'b0}}, 1'b1};

    xfer_state_t          r_state;
    xfer_state_t          w_next_state;
    logic [CW:0]          r_bit_cnt;
    logic [SPI_SS_NB-1:0] r_ss;
    logic                 r_irq;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_busy;
    logic                 w_unused_pos;

    // Rising edges never affect the count; kept only as a peer-interface port.
    assign w_unused_pos = cg_pos_edge;

    assign w_accept = r_state[IDLE_B] & start & ~abort;
    assign w_last   = r_state[RUN_B] & (r_bit_cnt == ONE_CNT);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (1'b1)
            r_state[IDLE_B]: begin
                if (w_accept) w_next_state = ST_RUN;
            end
            r_state[RUN_B]: begin
                if (abort)                    w_next_state = ST_IDLE;
                else if (cg_neg_edge && w_last) w_next_state = ST_FINISH;
            end
            r_state[FIN_B]: w_next_state = ST_IDLE;
            default:        w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = r_state[RUN_B] | r_state[FIN_B];
        cg_enable   = r_state[RUN_B];
        cg_go       = r_state[RUN_B];
        cg_last_clk = w_last;
        busy        = w_busy;
        done        = r_state[FIN_B];
        if (ass) ss_pad_o = w_busy ? ~r_ss : '1;
        else     ss_pad_o = ~ss_sel;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_ss      <= '0;
        end else if (w_accept) begin
            r_bit_cnt <= (char_len == '0) ? FULL_CNT : {1'b0, char_len};
            r_ss      <= ss_sel;
        end else if (r_state[RUN_B]) begin
            if (abort)
                r_bit_cnt <= '0;
            else if (cg_neg_edge && r_bit_cnt != '0)
                r_bit_cnt <= r_bit_cnt - ONE_CNT;
        end
    end

    // Set has priority over clear when both land in the same cycle.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)                    r_irq <= 1'b0;
        else if (r_state[FIN_B] && ie) r_irq <= 1'b1;
        else if (irq_clr)           r_irq <= 1'b0;
    end

    assign irq     = r_irq;
    assign bit_cnt = r_bit_cnt;

endmodule
